// File: rtl/fft_pkg.sv
// Shared FFT datapath constants, sample type and the bin bit-reversal helper.
package fft_pkg;

    localparam int FFT_LOG2N  = 7;
    localparam int FFT_N      = 1 << FFT_LOG2N;
    localparam int FFT_DATA_W = 32;

    typedef logic [FFT_DATA_W-1:0] fft_sample_t;

    // Reverses the low log2n bits of idx; callers size-cast the result to their index width.
    function automatic logic [31:0] bitrev(input logic [31:0] idx, input int unsigned log2n);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < int'(log2n)) begin
                r[i] = idx[5'(int'(log2n) - 1 - i)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_out_reorder_if.sv
// Sample stream bundle for the FFT output reorder stage: bit-reversed input side, natural-order output side.
interface fft_out_reorder_if #(
    parameter int DATA_W = fft_pkg::FFT_DATA_W,
    parameter int LOG2N  = fft_pkg::FFT_LOG2N
);
    logic [DATA_W-1:0] i_data;
    logic              i_data_valid;
    logic              o_data_ready;
    logic [DATA_W-1:0] o_data;
    logic              o_data_valid;
    logic              i_data_ready;
    logic [LOG2N-1:0]  o_index;
    logic              o_last;

    modport slave (
        input  i_data, i_data_valid, i_data_ready,
        output o_data_ready, o_data, o_data_valid, o_index, o_last
    );

    modport master (
        output i_data, i_data_valid, i_data_ready,
        input  o_data_ready, o_data, o_data_valid, o_index, o_last
    );
endinterface

// File: rtl/fft_pingpong_ram.sv
// Two-bank frame store: one write port, one read port with a registered (resettable) data output.
module fft_pingpong_ram
    import fft_pkg::*;
#(
    parameter int DATA_W = FFT_DATA_W,
    parameter int LOG2N  = FFT_LOG2N
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              wr_en,
    input  logic              wr_bank,
    input  logic [LOG2N-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic              rd_bank,
    input  logic [LOG2N-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    localparam int DEPTH = 2 << LOG2N;

    logic [DATA_W-1:0] mem [DEPTH];

    // Array itself carries no reset so it can map onto block RAM.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[{wr_bank, wr_addr}] <= wr_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[{rd_bank, rd_addr}];
        end
    end
endmodule

// File: rtl/fft_out_reorder.sv
// FFT output reorder: writes bit-reversed frames into a ping-pong store and streams them out in bin order.
// Build option FFT_OUT_REORDER_STATUS_EN adds o_frame_cnt and the sticky o_overflow flag.
module fft_out_reorder
    import fft_pkg::*;
#(
    parameter int DATA_W = FFT_DATA_W,
    parameter int LOG2N  = FFT_LOG2N
) (
    input  logic               i_clk,
    input  logic               i_rst,
    fft_out_reorder_if.slave   io
`ifdef FFT_OUT_REORDER_STATUS_EN
    ,
    output logic [15:0]        o_frame_cnt,
    output logic               o_overflow
`endif
);
    logic [1:0]        bank_full;
    logic [1:0]        full_set;
    logic [1:0]        full_clr;
    logic              wr_bank;
    logic              rd_bank;
    logic [LOG2N-1:0]  wr_cnt;
    logic [LOG2N-1:0]  rd_cnt;
    logic [LOG2N-1:0]  wr_addr;
    logic              accept;
    logic              fetch;
    logic              wr_last;
    logic              rd_last;
    logic [DATA_W-1:0] rd_data;

    assign io.o_data_ready = ~bank_full[wr_bank] & ~i_rst;
    assign accept          = io.i_data_valid & io.o_data_ready;
    assign fetch           = bank_full[rd_bank] & (~io.o_data_valid | io.i_data_ready);
    assign wr_last         = accept & (wr_cnt == '1);
    assign rd_last         = fetch & (rd_cnt == '1);
    assign wr_addr         = LOG2N'(bitrev(32'(wr_cnt), LOG2N));
    assign io.o_data       = rd_data;

    // Writer and reader always own different banks, so set and clear never collide.
    always_comb begin
        full_set          = '0;
        full_clr          = '0;
        full_set[wr_bank] = wr_last;
        full_clr[rd_bank] = rd_last;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            bank_full       <= '0;
            wr_bank         <= 1'b0;
            rd_bank         <= 1'b0;
            wr_cnt          <= '0;
            rd_cnt          <= '0;
            io.o_data_valid <= 1'b0;
            io.o_index      <= '0;
            io.o_last       <= 1'b0;
        end else begin
            bank_full <= (bank_full | full_set) & ~full_clr;
            if (accept) begin
                wr_cnt <= wr_cnt + 1'b1;
                if (wr_last) begin
                    wr_bank <= ~wr_bank;
                end
            end
            if (fetch) begin
                rd_cnt          <= rd_cnt + 1'b1;
                io.o_index      <= rd_cnt;
                io.o_last       <= (rd_cnt == '1);
                io.o_data_valid <= 1'b1;
                if (rd_last) begin
                    rd_bank <= ~rd_bank;
                end
            end else if (io.i_data_ready) begin
                io.o_data_valid <= 1'b0;
            end
        end
    end

    fft_pingpong_ram #(
        .DATA_W (DATA_W),
        .LOG2N  (LOG2N)
    ) u_ram (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .wr_en   (accept),
        .wr_bank (wr_bank),
        .wr_addr (wr_addr),
        .wr_data (io.i_data),
        .rd_en   (fetch),
        .rd_bank (rd_bank),
        .rd_addr (rd_cnt),
        .rd_data (rd_data)
    );

`ifdef FFT_OUT_REORDER_STATUS_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_frame_cnt <= '0;
            o_overflow  <= 1'b0;
        end else begin
            if (io.o_data_valid & io.i_data_ready & io.o_last) begin
                o_frame_cnt <= o_frame_cnt + 16'd1;
            end
            if (io.i_data_valid & ~io.o_data_ready) begin
                o_overflow <= 1'b1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_fft_out_reorder.sv
// Directed/random bench for fft_out_reorder with a natural-order scoreboard.
module tb_fft_out_reorder;
    import fft_pkg::*;

    localparam int N = 128;

    typedef struct {
        fft_sample_t d;
        logic [6:0]  idx;
        logic        last;
    } exp_t;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    always #5 i_clk = ~i_clk;

    fft_out_reorder_if #(.DATA_W(32), .LOG2N(7)) bus ();

`ifdef FFT_OUT_REORDER_STATUS_EN
    logic [15:0] frame_cnt;
    logic        overflow;
`endif

    fft_out_reorder dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .io    (bus)
`ifdef FFT_OUT_REORDER_STATUS_EN
        ,
        .o_frame_cnt (frame_cnt),
        .o_overflow  (overflow)
`endif
    );

    int   vectors     = 0;
    int   miscompares = 0;
    exp_t sb [$];
    bit   rnd_sink    = 1'b0;
    bit   watch_ready = 1'b0;
    int   ready_drops = 0;
    int   neg_cyc     = 0;
    int   out_cnt     = 0;
    int   first_out   = -1;
    int   last_out    = -1;

    function automatic int tb_rev(input int k);
        int r = 0;
        for (int b = 0; b < 7; b++) if (((k >> b) & 1) == 1) r |= (1 << (6 - b));
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Random sink; updated later in the cycle than the main sequence so the two never race.
    always @(posedge i_clk) begin
        #2;
        if (rnd_sink) bus.i_data_ready = ($urandom_range(1, 0) == 1);
    end

    fft_sample_t hold_d;
    logic [6:0]  hold_i;
    logic        hold_l;
    bit          hold_p = 1'b0;

    always @(negedge i_clk) begin
        exp_t e;
        neg_cyc++;
        if (watch_ready && !bus.o_data_ready) ready_drops++;
        if (!i_rst) begin
            if (hold_p) begin
                chk("hold_valid", bus.o_data_valid, 1'b1);
                chk("hold_data", bus.o_data, hold_d);
                chk("hold_index", bus.o_index, hold_i);
                chk("hold_last", bus.o_last, hold_l);
            end
            if (bus.o_data_valid && bus.i_data_ready) begin
                out_cnt++;
                if (first_out < 0) first_out = neg_cyc;
                last_out = neg_cyc;
                chk("sb_nonempty", sb.size() != 0, 1'b1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("out_data", bus.o_data, e.d);
                    chk("out_index", bus.o_index, e.idx);
                    chk("out_last", bus.o_last, e.last);
                end
            end
            hold_p = bus.o_data_valid && !bus.i_data_ready;
            hold_d = bus.o_data;
            hold_i = bus.o_index;
            hold_l = bus.o_last;
        end else begin
            hold_p = 1'b0;
        end
    end

    task automatic send_frame(input int base, input int count, input bit rnd);
        fft_sample_t frm [N];
        int k = 0;
        int t = 0;
        while (k < count) begin
            bus.i_data_valid = rnd ? ($urandom_range(1, 0) == 1) : 1'b1;
            bus.i_data       = fft_sample_t'(base + k);
            @(negedge i_clk);
            if (bus.i_data_valid && bus.o_data_ready) begin
                frm[k] = fft_sample_t'(base + k);
                k++;
            end
            @(posedge i_clk); #1;
            t++;
            if (t > 5000) begin
                chk("send_timeout", t, 0);
                break;
            end
        end
        bus.i_data_valid = 1'b0;
        if (k == N) begin
            for (int n = 0; n < N; n++) sb.push_back(exp_t'{frm[tb_rev(n)], 7'(n), n == N - 1});
        end
    endtask

    task automatic latency_check(input string tag);
        @(negedge i_clk); chk({tag, "_valid_e1"}, bus.o_data_valid, 1'b0);
        @(negedge i_clk); chk({tag, "_valid_e2"}, bus.o_data_valid, 1'b1);
        @(posedge i_clk); #1;
    endtask

    task automatic drain(input string tag);
        int t = 0;
        while ((sb.size() != 0 || bus.o_data_valid) && t < 3000) begin
            @(negedge i_clk);
            t++;
        end
        chk({tag, "_sb_left"}, sb.size(), 0);
        @(posedge i_clk); #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, bus.o_data_ready, 1'b0);
        chk({tag, "_valid"}, bus.o_data_valid, 1'b0);
        chk({tag, "_data"}, bus.o_data, 0);
        chk({tag, "_index"}, bus.o_index, 0);
        chk({tag, "_last"}, bus.o_last, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        bus.i_data       = '0;
        bus.i_data_valid = 1'b0;
        bus.i_data_ready = 1'b1;

        // Reset state, then release
        repeat (2) @(posedge i_clk);
        @(negedge i_clk); chk_reset_outputs("rst0");
        @(posedge i_clk); #1; i_rst = 1'b0;
        @(negedge i_clk); chk("ready_after_rst", bus.o_data_ready, 1'b1);
        @(posedge i_clk); #1;

        // Single frame 0..127, sink ready
        send_frame(0, N, 1'b0);
        latency_check("s1");
        drain("s1");
`ifdef FFT_OUT_REORDER_STATUS_EN
        chk("s1_frame_cnt", frame_cnt, 1);
        chk("s1_overflow", overflow, 1'b0);
`endif

        // Four back-to-back frames, no gaps, ready never drops
        out_cnt = 0; first_out = -1; ready_drops = 0; watch_ready = 1'b1;
        for (int f = 0; f < 4; f++) send_frame(f * N, N, 1'b0);
        watch_ready = 1'b0;
        drain("s2");
        chk("s2_out_cnt", out_cnt, 4 * N);
        chk("s2_span", last_out - first_out, 4 * N - 1);
        chk("s2_ready_drops", ready_drops, 0);
`ifdef FFT_OUT_REORDER_STATUS_EN
        chk("s2_frame_cnt", frame_cnt, 5);
`endif

        // Stalled sink fills both banks
        bus.i_data_ready = 1'b0;
        send_frame(0, N, 1'b0);
        send_frame(0, N, 1'b0);
        @(negedge i_clk);
        chk("s3_full_ready", bus.o_data_ready, 1'b0);
        chk("s3_valid", bus.o_data_valid, 1'b1);
        chk("s3_data", bus.o_data, 0);
        chk("s3_index", bus.o_index, 0);
        @(posedge i_clk); #1;
`ifdef FFT_OUT_REORDER_STATUS_EN
        bus.i_data_valid = 1'b1;
        @(posedge i_clk); #1;
        bus.i_data_valid = 1'b0;
        @(negedge i_clk);
        chk("s3_overflow_set", overflow, 1'b1);
        chk("s3_still_full", bus.o_data_ready, 1'b0);
        @(posedge i_clk); #1;
`endif
        bus.i_data_ready = 1'b1;
        repeat (126) @(posedge i_clk);
        @(negedge i_clk); chk("s3_ready_before_127th", bus.o_data_ready, 1'b0);
        @(negedge i_clk); chk("s3_ready_after_128th", bus.o_data_ready, 1'b1);
        @(posedge i_clk); #1;
        drain("s3");
`ifdef FFT_OUT_REORDER_STATUS_EN
        chk("s3_overflow_sticky", overflow, 1'b1);
`endif

        // Random valid/ready over 10 frames
        rnd_sink = 1'b1;
        for (int f = 0; f < 10; f++) send_frame(5000 + f * N, N, 1'b1);
        drain("s4");
        rnd_sink = 1'b0;
        bus.i_data_ready = 1'b1;

        // Reset mid-frame with one full frame pending
        bus.i_data_ready = 1'b0;
        send_frame(3000, N, 1'b0);
        send_frame(3200, 50, 1'b0);
        i_rst = 1'b1;
        @(negedge i_clk); chk_reset_outputs("s5_rst");
        sb.delete();
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        bus.i_data_ready = 1'b1;
        seen = 1'b0;
        repeat (200) begin
            @(negedge i_clk);
            if (bus.o_data_valid) seen = 1'b1;
        end
        chk("s5_valid_never", seen, 1'b0);
`ifdef FFT_OUT_REORDER_STATUS_EN
        chk("s5_frame_cnt_rst", frame_cnt, 0);
        chk("s5_overflow_rst", overflow, 1'b0);
`endif
        @(posedge i_clk); #1;
        send_frame(0, N, 1'b0);
        latency_check("s5");
        drain("s5");
`ifdef FFT_OUT_REORDER_STATUS_EN
        chk("s5_frame_cnt", frame_cnt, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
